// File: rtl/round_controller.sv
// rtl/round_controller.sv - session sequencer: request pattern, show it, time the response window, score
module round_controller #(
    parameter int TICK_DIV   = 300_000_000,
    parameter int SHOW_TICKS = 1,
    parameter int WAIT_TICKS = 1,
    parameter int NUM_ROUNDS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gen_req,
    input  logic       gen_ack,
    input  logic [3:0] gen_bits,
    input  logic [3:0] user_bits,
    output logic       disp_en,
    output logic [3:0] disp_bits,
    output logic       match,
    output logic [3:0] score,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SHOW,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [28:0] TICK_LAST  = 29'(TICK_DIV - 1);
    localparam logic [3:0]  SHOW_LAST  = 4'(SHOW_TICKS - 1);
    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_TICKS - 1);
    localparam logic [3:0]  ROUND_LAST = 4'(NUM_ROUNDS - 1);

    state_t      state;
    logic [28:0] tick_div_cnt;
    logic [3:0]  tick_cnt;
    logic [3:0]  pattern;
    logic [3:0]  sampled;
    logic        tick;
    logic        match_now;

    assign tick      = (tick_div_cnt == TICK_LAST);
    assign match_now = (sampled == pattern);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tick_div_cnt <= '0;
            tick_cnt     <= '0;
            pattern      <= '0;
            sampled      <= '0;
            gen_req      <= 1'b0;
            disp_en      <= 1'b0;
            disp_bits    <= '0;
            match        <= 1'b0;
            score        <= '0;
            round_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    state     <= S_REQ;
                    gen_req   <= 1'b1;
                    busy      <= 1'b1;
                    score     <= '0;
                    round_idx <= '0;
                    match     <= 1'b0;
                end
            end else if (abort) begin
                // Results of the interrupted session stay visible; only activity stops.
                state     <= S_IDLE;
                gen_req   <= 1'b0;
                disp_en   <= 1'b0;
                disp_bits <= '0;
                busy      <= 1'b0;
            end else begin
                if (state == S_SHOW || state == S_WAIT) begin
                    tick_div_cnt <= tick ? 29'd0 : tick_div_cnt + 29'd1;
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                case (state)
                    S_REQ: begin
                        if (gen_ack) begin
                            pattern      <= gen_bits;
                            gen_req      <= 1'b0;
                            disp_en      <= 1'b1;
                            disp_bits    <= gen_bits;
                            tick_div_cnt <= '0;
                            tick_cnt     <= '0;
                            state        <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (tick && tick_cnt == SHOW_LAST) begin
                            disp_en      <= 1'b0;
                            disp_bits    <= '0;
                            tick_div_cnt <= '0;
                            tick_cnt     <= '0;
                            state        <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (tick && tick_cnt == WAIT_LAST) begin
                            sampled <= user_bits;
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        match <= match_now;
                        if (match_now && score != 4'd15) begin
                            score <= score + 4'd1;
                        end
                        if (round_idx == ROUND_LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            round_idx <= round_idx + 4'd1;
                            gen_req   <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed and random checks of round_controller against a cycle-count model
module tb_round_controller;

    localparam int TD = 4;
    localparam int SH = 1;
    localparam int WT = 2;
    localparam int NR = 3;
    localparam int SHOW_CYC = TD * SH;
    localparam int WIN_CYC  = TD * (SH + WT);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       gen_req;
    logic       gen_ack;
    logic [3:0] gen_bits;
    logic [3:0] user_bits;
    logic       disp_en;
    logic [3:0] disp_bits;
    logic       match;
    logic [3:0] score;
    logic [3:0] round_idx;
    logic       busy;
    logic       done;

    round_controller #(
        .TICK_DIV(TD), .SHOW_TICKS(SH), .WAIT_TICKS(WT), .NUM_ROUNDS(NR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gen_req(gen_req), .gen_ack(gen_ack), .gen_bits(gen_bits),
        .user_bits(user_bits), .disp_en(disp_en), .disp_bits(disp_bits),
        .match(match), .score(score), .round_idx(round_idx),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model phases: 0 idle, 1 waiting for ack, 2 show+response window, 4 scoring, 5 done.
    // Window timing is counted in elapsed cycles since the pattern was acked.
    int         ph = 0;
    int         el = 0;
    logic [3:0] m_pat = '0, m_samp = '0;
    logic       e_req = 0, e_den = 0, e_match = 0, e_busy = 0, e_done = 0;
    logic [3:0] e_dbits = '0, e_score = '0, e_round = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph <= 0; e_req <= 0; e_den <= 0; e_dbits <= '0; e_match <= 0;
            e_score <= '0; e_round <= '0; e_busy <= 0; e_done <= 0;
        end else begin
            e_done <= 0;
            if (ph == 0) begin
                if (start) begin
                    ph <= 1; e_req <= 1; e_busy <= 1;
                    e_score <= '0; e_round <= '0; e_match <= 0;
                end
            end else if (abort) begin
                ph <= 0; e_req <= 0; e_den <= 0; e_dbits <= '0; e_busy <= 0;
            end else begin
                case (ph)
                    1: if (gen_ack) begin
                        m_pat <= gen_bits; e_req <= 0; e_den <= 1; e_dbits <= gen_bits;
                        el <= 0; ph <= 2;
                    end
                    2: if (el == WIN_CYC - 1) begin
                        m_samp <= user_bits; ph <= 4;
                    end else begin
                        el <= el + 1;
                        if (el + 1 == SHOW_CYC) begin e_den <= 0; e_dbits <= '0; end
                    end
                    4: begin
                        e_match <= (m_samp == m_pat);
                        if (m_samp == m_pat && e_score < 15) e_score <= e_score + 4'd1;
                        if (int'(e_round) == NR - 1) begin
                            e_done <= 1; ph <= 5;
                        end else begin
                            e_round <= e_round + 4'd1; e_req <= 1; ph <= 1;
                        end
                    end
                    5: begin e_busy <= 0; ph <= 0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gen_req",   int'(gen_req),   int'(e_req));
            chk("disp_en",   int'(disp_en),   int'(e_den));
            chk("disp_bits", int'(disp_bits), int'(e_dbits));
            chk("match",     int'(match),     int'(e_match));
            chk("score",     int'(score),     int'(e_score));
            chk("round_idx", int'(round_idx), int'(e_round));
            chk("busy",      int'(busy),      int'(e_busy));
            chk("done",      int'(done),      int'(e_done));
        end
    end

    logic       r_req[64], r_den[64], r_match[64], r_busy[64], r_done[64];
    logic [3:0] r_dbits[64], r_score[64], r_round[64];
    logic [3:0] s_score[64];
    logic       s_done[64], s_den[64];

    // Runs one scripted session from cycle 0 (start) for ncyc cycles; entered at posedge+2.
    task automatic run_dir(input logic [11:0] g, input logic [11:0] u, input int ack_hold,
                           input int abort_cyc, input int rst_cyc, input bit stray, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int  r;
            bit  ack_ok;
            r      = (e_round > 2) ? 2 : int'(e_round);
            ack_ok = (ph == 1) && (i >= 1 + ack_hold);
            start     = (i == 0) || (stray && (i == 20 || i == 21)) || (i == rst_cyc);
            abort     = (i == abort_cyc);
            rst_n     = (i != rst_cyc);
            gen_ack   = ack_ok || (stray && i == 3) || (i == rst_cyc);
            gen_bits  = ack_ok ? g[4*r +: 4] : 4'($urandom);
            user_bits = u[4*r +: 4];
            @(negedge clk);
            r_req[i] = gen_req; r_den[i] = disp_en; r_dbits[i] = disp_bits; r_match[i] = match;
            r_score[i] = score; r_round[i] = round_idx; r_busy[i] = busy; r_done[i] = done;
            @(posedge clk); #2;
        end
        start = 0; abort = 0; gen_ack = 0; rst_n = 1;
    endtask

    initial begin
        int cnt;
        rst_n = 0; start = 0; abort = 0; gen_ack = 0; gen_bits = '0; user_bits = '0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1;
        @(negedge clk);
        chk("reset_outputs", int'({gen_req, disp_en, disp_bits, match, score, round_idx, busy, done}), 0);
        @(posedge clk); #2;

        // Single matched session
        run_dir(12'hAAA, 12'hAAA, 0, -1, -1, 1'b0, 50);
        chk("t1_req_c1", int'(r_req[1]), 1);
        chk("t1_busy_c0", int'(r_busy[0]), 0);
        chk("t1_den_c1", int'(r_den[1]), 0);
        chk("t1_den_c2", int'(r_den[2]), 1);
        chk("t1_den_c5", int'(r_den[5]), 1);
        chk("t1_den_c6", int'(r_den[6]), 0);
        chk("t1_dbits_c2", int'(r_dbits[2]), 10);
        chk("t1_score_c14", int'(r_score[14]), 0);
        chk("t1_score_c15", int'(r_score[15]), 1);
        chk("t1_done_c42", int'(r_done[42]), 0);
        chk("t1_done_c43", int'(r_done[43]), 1);
        chk("t1_done_c44", int'(r_done[44]), 0);
        chk("t1_score_final", int'(r_score[43]), 3);
        chk("t1_match_final", int'(r_match[43]), 1);
        chk("t1_round_final", int'(r_round[43]), 2);
        chk("t1_busy_c44", int'(r_busy[44]), 0);
        for (int i = 0; i < 50; i++) begin
            s_score[i] = r_score[i]; s_done[i] = r_done[i]; s_den[i] = r_den[i];
        end

        // Mixed results: patterns 3,5,9 answered with 3,4,9
        run_dir(12'h953, 12'h943, 0, -1, -1, 1'b0, 50);
        chk("t2_match_r0", int'(r_match[15]), 1);
        chk("t2_match_r1", int'(r_match[29]), 0);
        chk("t2_match_r2", int'(r_match[43]), 1);
        chk("t2_score", int'(r_score[43]), 2);
        chk("t2_round", int'(r_round[43]), 2);

        // Ack held off for 5 cycles in the first REQ
        run_dir(12'h666, 12'h666, 5, -1, -1, 1'b0, 55);
        cnt = 0;
        for (int i = 0; i < 14; i++) cnt += int'(r_req[i]);
        chk("t3_req_cycles", cnt, 6);
        chk("t3_den_c6", int'(r_den[6]), 0);
        chk("t3_den_c7", int'(r_den[7]), 1);
        chk("t3_dbits_c7", int'(r_dbits[7]), 6);
        chk("t3_done_c48", int'(r_done[48]), 1);

        // Abort during the round-1 response window, then restart
        run_dir(12'hCCC, 12'hCCC, 0, 22, -1, 1'b0, 40);
        cnt = 0;
        for (int i = 0; i < 40; i++) cnt += int'(r_done[i]);
        chk("t4_no_done", cnt, 0);
        chk("t4_busy_c23", int'(r_busy[23]), 0);
        chk("t4_den_c23", int'(r_den[23]), 0);
        chk("t4_req_c23", int'(r_req[23]), 0);
        chk("t4_score_c23", int'(r_score[23]), 1);
        chk("t4_round_c23", int'(r_round[23]), 1);
        run_dir(12'h111, 12'h000, 0, 4, -1, 1'b0, 8);
        chk("t4b_score_cleared", int'(r_score[1]), 0);
        chk("t4b_busy", int'(r_busy[1]), 1);

        // Reset during SHOW with start and ack asserted alongside it
        run_dir(12'h777, 12'h777, 0, -1, 3, 1'b0, 12);
        chk("t5_outputs_zero", int'({r_req[4], r_den[4], r_dbits[4], r_match[4], r_score[4],
                                     r_round[4], r_busy[4], r_done[4]}), 0);
        chk("t5_stays_idle", int'(r_busy[10]), 0);

        // Start re-pulsed mid-session and a stray ack during SHOW
        run_dir(12'hAAA, 12'hAAA, 0, -1, -1, 1'b1, 50);
        cnt = 0;
        for (int i = 0; i < 50; i++)
            if (r_score[i] != s_score[i] || r_done[i] != s_done[i] || r_den[i] != s_den[i]) cnt++;
        chk("t6_timing_identical", cnt, 0);
        chk("t6_done_c43", int'(r_done[43]), 1);

        // Random stimulus; the compare process checks every cycle
        for (int k = 0; k < 8000; k++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            gen_ack   = ($urandom_range(0, 2) == 0);
            gen_bits  = 4'($urandom);
            user_bits = ($urandom_range(0, 1) != 0) ? m_pat : 4'($urandom);
            @(posedge clk); #2;
        end
        rst_n = 1; start = 0; abort = 0; gen_ack = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
